rr_grant_scheduler: RTL
=======================

Name: rr_grant_scheduler

Overview:
- 16-requester round-robin arbiter that shares one downstream resource, the 16-bit priority-encoded datapath, between requesters.
- Registers a single grant, holds it until the owner releases or a hold timeout expires, then rotates priority to the next requester after the last winner.
- Sits between the 16 request lines and the shared resource.
- Drives a 4-bit grant index plus a one-hot grant, so the encoder's input stage is sequenced one owner at a time.

Parameters:
MAX_HOLD, 255, maximum BUSY cycles per grant; 0 disables the timeout.
CNT_W, 8, hold counter width; must satisfy MAX_HOLD <= 2^CNT_W-1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
en  input  1  arbitration enable; when low, no new grants are issued.
req  input  16  request lines, level-sensitive; bit i is requester i.
done  input  1  owner release strobe, sampled in BUSY only.
grant_valid  output  1  a grant is active.
grant_idx  output  4  index of the current owner; 0 when no grant is active.
grant_onehot  output  16  one-hot of grant_idx when grant_valid=1, else 0.
timeout_pulse  output  1  one-cycle pulse when a grant ends by timeout.
busy_cnt  output  CNT_W  cycles the current grant has been held; 0 in IDLE.

Behaviour:
- Reset: state=IDLE, grant_valid=0, grant_idx=0, grant_onehot=0, timeout_pulse=0, busy_cnt=0, last_idx=15.
- Reset asserted mid-grant drops all outputs immediately (asynchronous).
- States: IDLE and BUSY. All outputs are registered.
- IDLE:
  - Entry condition: en=1 and req!=0.
  - Winner: the first set bit searching upward from (last_idx+1) mod 16, wrapping 15->0.
  - Next edge: state=BUSY, grant_idx=winner, grant_onehot=1<<winner, grant_valid=1, busy_cnt=1, last_idx=winner.
  - Latency: req seen in cycle N gives grant_valid=1 in cycle N+1.
  - If en=0 or req=0: stay in IDLE, outputs hold their reset values except last_idx.
- BUSY release conditions, evaluated each cycle:
  - (a) done=1;
  - (b) req[grant_idx]=0, i.e. the owner dropped its request;
  - (c) MAX_HOLD!=0 and busy_cnt==MAX_HOLD.
- Any release condition in cycle N: at the N+1 edge, state=IDLE, grant_valid=0, grant_idx=0, grant_onehot=0, busy_cnt=0.
- Dead cycle: there is always at least one IDLE cycle (grant_valid=0) between two grants.
  - Arbitration for the next grant uses req sampled in that IDLE cycle.
  - The next grant therefore appears at the earliest in cycle N+2.
- timeout_pulse=1 in cycle N+1 only when (c) caused the release and neither (a) nor (b) was true in cycle N.
  - If (a) or (b) coincides with (c), release is normal and there is no pulse.
- No release: busy_cnt increments and saturates at 2^CNT_W-1 (reachable only when MAX_HOLD=0). grant_idx stays stable.
- With MAX_HOLD=M>0 and no done/drop, grant_valid is high for exactly M cycles.
- en=0 during BUSY does not affect the current grant; it only blocks the next one.
- done in IDLE is ignored. Changes to non-owner req bits during BUSY are ignored.
- A requester holding req high through its own release is eligible again only after all other pending requesters (round-robin fairness).
- Single requester: re-granted after each dead cycle, giving a grant pattern of 1 cycle off, then BUSY.

Test Plan:
1. Reset check: assert rst_n=0 mid-run with req=0xFFFF -> all outputs 0 the same cycle; after release with req=0x0001, grant_idx=0 one cycle later (last_idx=15 at reset).
2. Basic handshake: req=0x0010, en=1 -> grant_valid=1, grant_idx=4, grant_onehot=0x0010 next cycle; done=1 for one cycle -> grant_valid=0 next cycle, then re-grant to 4 one cycle later.
3. Round-robin order: req=0x8101 held, done pulsed once per grant -> grant_idx sequence 0, 8, 15, 0, 8, with one dead cycle between grants.
4. Timeout: MAX_HOLD=4, req=0x0006, no done -> idx1 granted for exactly 4 cycles, busy_cnt 1..4, timeout_pulse=1 for one cycle, then idx2 granted; with done=1 in the 4th cycle -> no pulse.
5. Owner drop and enable: grant idx3, deassert req[3] -> release next cycle, timeout_pulse=0; en=0 with req=0xFFFF in IDLE -> no grant; en=1 -> grant to the next index after the last winner.
6. Ignored inputs: done pulses in IDLE and toggling of non-owner req bits during BUSY -> no state change; busy_cnt keeps incrementing.

Source files
------------

// File: rtl/rr_grant_scheduler.sv
// 16-requester round-robin arbiter with registered grant, owner release, and hold timeout.
// One dead IDLE cycle separates consecutive grants; priority rotates past the last winner.
module rr_grant_scheduler #(
   parameter int unsigned MAX_HOLD = 255,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [15:0]      req,
   input  logic             done,
   output logic             grant_valid,
   output logic [3:0]       grant_idx,
   output logic [15:0]      grant_onehot,
   output logic             timeout_pulse,
   output logic [CNT_W-1:0] busy_cnt
);

   localparam int unsigned NREQ = 16;
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t            r_state, w_state_nxt;
   logic [3:0]        r_last_idx, w_last_nxt;
   logic              r_grant_valid, w_valid_nxt;
   logic [3:0]        r_grant_idx, w_idx_nxt;
   logic [15:0]       r_grant_onehot, w_oh_nxt;
   logic              r_timeout_pulse, w_to_nxt;
   logic [CNT_W-1:0]  r_busy_cnt, w_cnt_nxt;

   logic [3:0]        w_winner;
   logic              w_found;
   logic              w_rel_done, w_rel_drop, w_rel_to;

   // Round-robin search starting one past the last winner, wrapping 15 -> 0.
   always_comb begin
      w_found  = 1'b0;
      w_winner = 4'd0;
      for (int i = 0; i < int'(NREQ); i++) begin
         logic [3:0] w_cand;
         w_cand = r_last_idx + 4'(i + 1);
         if (!w_found && req[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   assign w_rel_done = done;
   assign w_rel_drop = ~req[r_grant_idx];
   assign w_rel_to   = (MAX_HOLD != 0) && (r_busy_cnt == HOLD_LIM);

   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = 1'b0;
      w_idx_nxt   = 4'd0;
      w_oh_nxt    = 16'd0;
      w_to_nxt    = 1'b0;
      w_cnt_nxt   = '0;
      w_last_nxt  = r_last_idx;
      case (r_state)
         S_IDLE: begin
            if (en && w_found) begin
               w_state_nxt = S_BUSY;
               w_valid_nxt = 1'b1;
               w_idx_nxt   = w_winner;
               w_oh_nxt    = 16'(1) << w_winner;
               w_cnt_nxt   = CNT_W'(1);
               w_last_nxt  = w_winner;
            end
         end
         S_BUSY: begin
            if (w_rel_done || w_rel_drop || w_rel_to) begin
               // A pulse only when the timeout alone ended the grant.
               w_state_nxt = S_IDLE;
               w_to_nxt    = w_rel_to && !w_rel_done && !w_rel_drop;
            end else begin
               w_valid_nxt = 1'b1;
               w_idx_nxt   = r_grant_idx;
               w_oh_nxt    = r_grant_onehot;
               w_cnt_nxt   = (r_busy_cnt == CNT_SAT) ? r_busy_cnt : r_busy_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_last_idx      <= 4'd15;
         r_grant_valid   <= 1'b0;
         r_grant_idx     <= 4'd0;
         r_grant_onehot  <= 16'd0;
         r_timeout_pulse <= 1'b0;
         r_busy_cnt      <= '0;
      end else begin
         r_state         <= w_state_nxt;
         r_last_idx      <= w_last_nxt;
         r_grant_valid   <= w_valid_nxt;
         r_grant_idx     <= w_idx_nxt;
         r_grant_onehot  <= w_oh_nxt;
         r_timeout_pulse <= w_to_nxt;
         r_busy_cnt      <= w_cnt_nxt;
      end
   end

   assign grant_valid   = r_grant_valid;
   assign grant_idx     = r_grant_idx;
   assign grant_onehot  = r_grant_onehot;
   assign timeout_pulse = r_timeout_pulse;
   assign busy_cnt      = r_busy_cnt;

endmodule
